// File: rtl/tri_sweep_pkg.sv
// rtl/tri_sweep_pkg.sv - shared state encoding and widths for the triangle sweep controller
// TRI_SWEEP_BIDIR_EN adds the DOWN state for up-then-down sweeps.
package tri_sweep_pkg;

  localparam int FREQ_W_DEF  = 32;
  localparam int DWELL_W_DEF = 16;

  // Field widths of the 16-channel triangle bank (triangle_16chl)
  localparam int PCW_W = 10;
  localparam int AMP_W = 16;
  localparam int DC_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DWELL,
    ST_STEP,
    ST_DONE
`ifdef TRI_SWEEP_BIDIR_EN
    , ST_DOWN
`endif
  } sweep_state_e;

endpackage

// File: rtl/tri_dwell_timer.sv
// rtl/tri_dwell_timer.sv - loadable down-counter giving a terminal-count pulse per sweep point
module tri_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // tc is only seen while enabled, so the owner leaves its wait state on it
  assign tc = en && (cnt_q <= W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tri_sweep_ctrl.sv
// rtl/tri_sweep_ctrl.sv - frequency sweep sequencer driving the 16-channel triangle bank
// Optional TRI_SWEEP_BIDIR_EN: after reaching stop, sweep back down to start.
module tri_sweep_ctrl
  import tri_sweep_pkg::*;
#(
  parameter int FREQ_W  = FREQ_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FREQ_W-1:0]  cfg_start_freq,
  input  logic [FREQ_W-1:0]  cfg_stop_freq,
  input  logic [FREQ_W-1:0]  cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [PCW_W-1:0]   cfg_pcw,
  input  logic [AMP_W-1:0]   cfg_amp,
  input  logic [DC_W-1:0]    cfg_dc,
  input  logic               start,
  input  logic               abort,
  output logic [FREQ_W-1:0]  DDS_FREQ_VIO,
  output logic [PCW_W-1:0]   DDS_PCW_VIO,
  output logic [AMP_W-1:0]   DDS_AMP_VIO,
  output logic [DC_W-1:0]    DDS_DC_OFFSET_VIO,
  output logic               busy,
  output logic               step_strobe,
  output logic               sweep_done
);

  sweep_state_e state_q, state_d;

  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic [PCW_W-1:0]   pcw_q, pcw_d;
  logic [AMP_W-1:0]   amp_q, amp_d;
  logic [DC_W-1:0]    dc_q, dc_d;
  logic               busy_q, busy_d;
  logic               strobe_q, strobe_d;
  logic               done_q, done_d;

  logic [FREQ_W-1:0]  sh_start_q, sh_start_d;
  logic [FREQ_W-1:0]  sh_stop_q, sh_stop_d;
  logic [FREQ_W-1:0]  sh_step_q, sh_step_d;
  logic [DWELL_W-1:0] sh_dwell_q, sh_dwell_d;
  logic [PCW_W-1:0]   sh_pcw_q, sh_pcw_d;
  logic [AMP_W-1:0]   sh_amp_q, sh_amp_d;
  logic [DC_W-1:0]    sh_dc_q, sh_dc_d;

  logic [FREQ_W:0]    sum_w;
  logic [DWELL_W-1:0] dwell_ld;
  logic               tmr_load, tmr_tc;

`ifdef TRI_SWEEP_BIDIR_EN
  logic [FREQ_W:0]    diff_w;
  logic               down_q, down_d;
  logic               go_down;
`endif

  // The LOAD/STEP cycle is the first cycle of each point, so the timer
  // covers the remaining dwell-1 cycles; dwell 0 and 1 give the minimum point.
  assign dwell_ld = (sh_dwell_q > DWELL_W'(1)) ? (sh_dwell_q - DWELL_W'(1)) : DWELL_W'(1);

  tri_dwell_timer #(.W(DWELL_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (dwell_ld),
    .en       (state_q == ST_DWELL),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d    = state_q;
    freq_d     = freq_q;
    pcw_d      = pcw_q;
    amp_d      = amp_q;
    dc_d       = dc_q;
    strobe_d   = 1'b0;
    sh_start_d = sh_start_q;
    sh_stop_d  = sh_stop_q;
    sh_step_d  = sh_step_q;
    sh_dwell_d = sh_dwell_q;
    sh_pcw_d   = sh_pcw_q;
    sh_amp_d   = sh_amp_q;
    sh_dc_d    = sh_dc_q;
    tmr_load   = 1'b0;
    sum_w      = {1'b0, freq_q} + {1'b0, sh_step_q};
`ifdef TRI_SWEEP_BIDIR_EN
    down_d     = down_q;
    go_down    = 1'b0;
    diff_w     = {1'b0, freq_q} - {1'b0, sh_step_q};
`endif

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          sh_start_d = cfg_start_freq;
          sh_stop_d  = cfg_stop_freq;
          sh_step_d  = cfg_step;
          sh_dwell_d = cfg_dwell;
          sh_pcw_d   = cfg_pcw;
          sh_amp_d   = cfg_amp;
          sh_dc_d    = cfg_dc;
        end
        if (start) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        freq_d   = sh_start_q;
        pcw_d    = sh_pcw_q;
        amp_d    = sh_amp_q;
        dc_d     = sh_dc_q;
        strobe_d = 1'b1;
        tmr_load = 1'b1;
        state_d  = ST_DWELL;
`ifdef TRI_SWEEP_BIDIR_EN
        down_d   = 1'b0;
`endif
      end
      ST_DWELL: begin
        if (tmr_tc) begin
`ifdef TRI_SWEEP_BIDIR_EN
          state_d = down_q ? ST_DOWN : ST_STEP;
`else
          state_d = ST_STEP;
`endif
        end
      end
      ST_STEP: begin
        // Stop point already held for a dwell (or nothing to sweep): finish
        if ((freq_q < sh_stop_q) && (sh_step_q != '0)) begin
          freq_d   = (sum_w >= {1'b0, sh_stop_q}) ? sh_stop_q : sum_w[FREQ_W-1:0];
          strobe_d = 1'b1;
          tmr_load = 1'b1;
          state_d  = ST_DWELL;
        end else begin
`ifdef TRI_SWEEP_BIDIR_EN
          go_down = 1'b1;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef TRI_SWEEP_BIDIR_EN
      ST_DOWN: begin
        go_down = 1'b1;
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef TRI_SWEEP_BIDIR_EN
    if (go_down) begin
      if ((freq_q <= sh_start_q) || (sh_step_q == '0)) begin
        state_d = ST_DONE;
      end else begin
        freq_d   = (diff_w[FREQ_W] || (diff_w[FREQ_W-1:0] < sh_start_q)) ?
                   sh_start_q : diff_w[FREQ_W-1:0];
        down_d   = 1'b1;
        strobe_d = 1'b1;
        tmr_load = 1'b1;
        state_d  = ST_DWELL;
      end
    end
`endif

    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      freq_d   = freq_q;
      pcw_d    = pcw_q;
      amp_d    = amp_q;
      dc_d     = dc_q;
      strobe_d = 1'b0;
      tmr_load = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      freq_q     <= '0;
      pcw_q      <= '0;
      amp_q      <= '0;
      dc_q       <= '0;
      busy_q     <= 1'b0;
      strobe_q   <= 1'b0;
      done_q     <= 1'b0;
      sh_start_q <= '0;
      sh_stop_q  <= '0;
      sh_step_q  <= '0;
      sh_dwell_q <= '0;
      sh_pcw_q   <= '0;
      sh_amp_q   <= '0;
      sh_dc_q    <= '0;
`ifdef TRI_SWEEP_BIDIR_EN
      down_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      freq_q     <= freq_d;
      pcw_q      <= pcw_d;
      amp_q      <= amp_d;
      dc_q       <= dc_d;
      busy_q     <= busy_d;
      strobe_q   <= strobe_d;
      done_q     <= done_d;
      sh_start_q <= sh_start_d;
      sh_stop_q  <= sh_stop_d;
      sh_step_q  <= sh_step_d;
      sh_dwell_q <= sh_dwell_d;
      sh_pcw_q   <= sh_pcw_d;
      sh_amp_q   <= sh_amp_d;
      sh_dc_q    <= sh_dc_d;
`ifdef TRI_SWEEP_BIDIR_EN
      down_q     <= down_d;
`endif
    end
  end

  assign cfg_ready         = (state_q == ST_IDLE);
  assign DDS_FREQ_VIO      = freq_q;
  assign DDS_PCW_VIO       = pcw_q;
  assign DDS_AMP_VIO       = amp_q;
  assign DDS_DC_OFFSET_VIO = dc_q;
  assign busy              = busy_q;
  assign step_strobe       = strobe_q;
  assign sweep_done        = done_q;

endmodule

// File: tb/tb_tri_sweep_ctrl.sv
// tb/tb_tri_sweep_ctrl.sv - directed self-checking bench for tri_sweep_ctrl
module tb_tri_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_ready;
  logic [31:0] cfg_start_freq, cfg_stop_freq, cfg_step;
  logic [15:0] cfg_dwell;
  logic [9:0]  cfg_pcw;
  logic [15:0] cfg_amp, cfg_dc;
  logic        start, abort;
  logic [31:0] DDS_FREQ_VIO;
  logic [9:0]  DDS_PCW_VIO;
  logic [15:0] DDS_AMP_VIO, DDS_DC_OFFSET_VIO;
  logic        busy, step_strobe, sweep_done;

  int vectors = 0;
  int miscompares = 0;
  int cap_f[$];
  int cap_h[$];
  logic poke_ready;

  always #5 clk = ~clk;

  tri_sweep_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_valid         (cfg_valid),
    .cfg_ready         (cfg_ready),
    .cfg_start_freq    (cfg_start_freq),
    .cfg_stop_freq     (cfg_stop_freq),
    .cfg_step          (cfg_step),
    .cfg_dwell         (cfg_dwell),
    .cfg_pcw           (cfg_pcw),
    .cfg_amp           (cfg_amp),
    .cfg_dc            (cfg_dc),
    .start             (start),
    .abort             (abort),
    .DDS_FREQ_VIO      (DDS_FREQ_VIO),
    .DDS_PCW_VIO       (DDS_PCW_VIO),
    .DDS_AMP_VIO       (DDS_AMP_VIO),
    .DDS_DC_OFFSET_VIO (DDS_DC_OFFSET_VIO),
    .busy              (busy),
    .step_strobe       (step_strobe),
    .sweep_done        (sweep_done)
  );

  task automatic configure(input int s, input int e, input int st, input int dw);
    @(negedge clk);
    cfg_start_freq = 32'(s);
    cfg_stop_freq  = 32'(e);
    cfg_step       = 32'(st);
    cfg_dwell      = 16'(dw);
    cfg_valid      = 1'b1;
    @(negedge clk);
    cfg_valid      = 1'b0;
  endtask

  // Records each point (value at its step_strobe) and how many cycles it is shown before the next point or sweep_done
  task automatic capture(input int budget, input int poke_at, output bit done_seen);
    cap_f.delete();
    cap_h.delete();
    done_seen = 1'b0;
    for (int cyc = 0; cyc < budget && !done_seen; cyc++) begin
      @(negedge clk);
      start     = 1'b0;
      cfg_valid = 1'b0;
      if (sweep_done) begin
        done_seen = 1'b1;
      end else if (step_strobe) begin
        cap_f.push_back(int'(DDS_FREQ_VIO));
        cap_h.push_back(1);
      end else if (cap_h.size() > 0) begin
        cap_h[cap_h.size()-1] = cap_h[cap_h.size()-1] + 1;
      end
      if (cyc == poke_at) begin
        poke_ready     = cfg_ready;
        start          = 1'b1;
        cfg_valid      = 1'b1;
        cfg_start_freq = 32'd7777;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({DDS_FREQ_VIO, DDS_PCW_VIO, DDS_AMP_VIO, DDS_DC_OFFSET_VIO} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got freq=%0d pcw=%0d amp=%0d dc=%0d want all 0",
               DDS_FREQ_VIO, DDS_PCW_VIO, DDS_AMP_VIO, DDS_DC_OFFSET_VIO);
    end
    vectors++;
    if ({busy, step_strobe, sweep_done} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got busy/strobe/done=%b want 000", {busy, step_strobe, sweep_done});
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready);
    end
  endtask

  task automatic test_basic_sweep;
    int ef[$];
    bit done;
    ef = '{100, 200, 300, 400};
    cfg_pcw = 10'h155; cfg_amp = 16'h1234; cfg_dc = 16'h0F0F;
    configure(100, 400, 100, 3);
    start = 1'b1;
    capture(200, -1, done);
    vectors++;
    if (!done || cap_f.size() != 4) begin
      miscompares++;
      $display("FAIL basic_count: got done=%0d points=%0d want done=1 points=4", done, cap_f.size());
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= cap_f.size() || cap_f[i] != ef[i] || cap_h[i] != 3) begin
        miscompares++;
        $display("FAIL basic_point%0d: got freq=%0d hold=%0d want freq=%0d hold=3", i,
                 (i < cap_f.size()) ? cap_f[i] : -1, (i < cap_h.size()) ? cap_h[i] : -1, ef[i]);
      end
    end
    vectors++;
    if (busy !== 1'b1 || DDS_FREQ_VIO !== 32'd400) begin
      miscompares++;
      $display("FAIL basic_done_state: got busy=%b freq=%0d want busy=1 freq=400", busy, DDS_FREQ_VIO);
    end
    @(negedge clk);
    vectors++;
    if (sweep_done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_after: got done=%b busy=%b ready=%b want 0 0 1", sweep_done, busy, cfg_ready);
    end
    vectors++;
    if (DDS_PCW_VIO !== 10'h155 || DDS_AMP_VIO !== 16'h1234 || DDS_DC_OFFSET_VIO !== 16'h0F0F) begin
      miscompares++;
      $display("FAIL basic_bank: got pcw=%h amp=%h dc=%h want 155 1234 0f0f",
               DDS_PCW_VIO, DDS_AMP_VIO, DDS_DC_OFFSET_VIO);
    end
  endtask

  task automatic test_no_overshoot;
    int ef[$];
    bit done;
    ef = '{100, 200, 300, 350};
    configure(100, 350, 100, 2);
    start = 1'b1;
    capture(200, -1, done);
    vectors++;
    if (!done || cap_f.size() != 4) begin
      miscompares++;
      $display("FAIL clamp_count: got done=%0d points=%0d want done=1 points=4", done, cap_f.size());
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= cap_f.size() || cap_f[i] != ef[i] || cap_h[i] != 2) begin
        miscompares++;
        $display("FAIL clamp_point%0d: got freq=%0d hold=%0d want freq=%0d hold=2", i,
                 (i < cap_f.size()) ? cap_f[i] : -1, (i < cap_h.size()) ? cap_h[i] : -1, ef[i]);
      end
    end
  endtask

  task automatic test_degenerate;
    bit done;
    configure(500, 200, 100, 2);
    start = 1'b1;
    capture(100, -1, done);
    vectors++;
    if (!done || cap_f.size() != 1 || cap_f[0] != 500 || cap_h[0] != 2 || DDS_FREQ_VIO !== 32'd500) begin
      miscompares++;
      $display("FAIL reversed_range: got done=%0d points=%0d freq=%0d want done=1 points=1 freq=500",
               done, cap_f.size(), DDS_FREQ_VIO);
    end
    configure(100, 400, 0, 2);
    start = 1'b1;
    capture(100, -1, done);
    vectors++;
    if (!done || cap_f.size() != 1 || DDS_FREQ_VIO !== 32'd100) begin
      miscompares++;
      $display("FAIL step_zero: got done=%0d points=%0d freq=%0d want done=1 points=1 freq=100",
               done, cap_f.size(), DDS_FREQ_VIO);
    end
    configure(100, 200, 100, 0);
    start = 1'b1;
    capture(100, -1, done);
    vectors++;
    if (!done || cap_f.size() != 2 || cap_f[1] != 200) begin
      miscompares++;
      $display("FAIL dwell_zero: got done=%0d points=%0d want done=1 points=2 last=200", done, cap_f.size());
    end
  endtask

  task automatic test_start_ignored;
    bit done;
    configure(100, 300, 100, 2);
    start = 1'b1;
    poke_ready = 1'bx;
    capture(200, 3, done);
    vectors++;
    if (!done || cap_f.size() != 3 || cap_f[0] != 100 || cap_f[2] != 300) begin
      miscompares++;
      $display("FAIL midsweep_start: got done=%0d points=%0d want done=1 points=3 (100..300)", done, cap_f.size());
    end
    vectors++;
    if (poke_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_cfg_ready: got %b want 0", poke_ready);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_in_done: got busy=%b want 0", busy);
    end
    start = 1'b1;
    capture(200, -1, done);
    vectors++;
    if (!done || cap_f.size() != 3 || cap_f[0] != 100) begin
      miscompares++;
      $display("FAIL shadow_kept: got done=%0d points=%0d first=%0d want 1 3 100", done, cap_f.size(),
               (cap_f.size() > 0) ? cap_f[0] : -1);
    end
  endtask

  task automatic test_abort;
    int n;
    bit seen;
    configure(100, 400, 100, 3);
    start = 1'b1;
    n = 0;
    for (int c = 0; c < 50 && n < 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (step_strobe) n++;
    end
    vectors++;
    if (n != 2) begin
      miscompares++;
      $display("FAIL abort_wait: got strobes=%0d want 2 (timeout)", n);
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || DDS_FREQ_VIO !== 32'd200 || cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_dwell: got busy=%b freq=%0d ready=%b want 0 200 1", busy, DDS_FREQ_VIO, cfg_ready);
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (sweep_done || step_strobe || DDS_FREQ_VIO !== 32'd200) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL abort_quiet: got activity=1 want none after abort");
    end
    configure(100, 400, 100, 3);
    start = 1'b1;
    n = 0;
    for (int c = 0; c < 50 && n < 1; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (step_strobe) n++;
    end
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || DDS_FREQ_VIO !== 32'd100 || step_strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_step: got busy=%b freq=%0d strobe=%b want 0 100 0", busy, DDS_FREQ_VIO, step_strobe);
    end
  endtask

  task automatic test_async_reset;
    int n;
    configure(100, 400, 100, 3);
    start = 1'b1;
    n = 0;
    for (int c = 0; c < 50 && n < 1; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (step_strobe) n++;
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({DDS_FREQ_VIO, DDS_PCW_VIO, DDS_AMP_VIO, DDS_DC_OFFSET_VIO} !== '0 ||
        {busy, step_strobe, sweep_done} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_reset: got freq=%0d busy=%b strobe=%b want all 0", DDS_FREQ_VIO, busy, step_strobe);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_in_reset: got busy=%b want 0", busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || sweep_done !== 1'b0) begin
      miscompares++;
      $display("FAIL after_release: got ready=%b busy=%b done=%b want 1 0 0", cfg_ready, busy, sweep_done);
    end
  endtask

  task automatic test_bidir;
    int ef[$];
    bit done;
`ifdef TRI_SWEEP_BIDIR_EN
    ef = '{0, 100, 200, 300, 200, 100, 0};
`else
    ef = '{0, 100, 200, 300};
`endif
    configure(0, 300, 100, 1);
    start = 1'b1;
    capture(200, -1, done);
    vectors++;
    if (!done || cap_f.size() != ef.size()) begin
      miscompares++;
      $display("FAIL sweep_shape_count: got done=%0d points=%0d want done=1 points=%0d", done, cap_f.size(), ef.size());
    end
    for (int i = 0; i < ef.size(); i++) begin
      vectors++;
      if (i >= cap_f.size() || cap_f[i] != ef[i]) begin
        miscompares++;
        $display("FAIL sweep_shape%0d: got %0d want %0d", i, (i < cap_f.size()) ? cap_f[i] : -1, ef[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_start_freq = '0; cfg_stop_freq = '0; cfg_step = '0; cfg_dwell = '0;
    cfg_pcw = '0; cfg_amp = '0; cfg_dc = '0; poke_ready = 1'b0;
    test_reset();
    test_basic_sweep();
    test_no_overshoot();
    test_degenerate();
    test_start_ignored();
    test_abort();
    test_async_reset();
    test_bidir();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
